// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : data_mem_pkg                                               |
// | Description : Shared encodings for the data-memory responder: access     |
// |               size codes, FSM states and the wait-counter width.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package data_mem_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : data_mem_responder_if                                      |
// | Description : Memory-stage data-access bus between a requester (master)  |
// |               and the data-memory responder (slave).                     |
// | Signals     : req_valid/req_ready handshake, req_write, req_addr[31:0],  |
// |               req_wdata[31:0], req_size[1:0], req_unsigned,              |
// |               resp_valid pulse, resp_rdata[31:0], resp_error, busy.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );

endinterface : data_mem_responder_if
`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_lane_align                                             |
// | Description : Little-endian lane steering. Load path extracts the byte/  |
// |               half/word from a memory word and extends it; store path    |
// |               replicates store data onto all lanes and produces the byte |
// |               write mask.                                                |
// | Ports       : rword_i    memory word being read                          |
// |               offset_i   byte offset within the word (already aligned)   |
// |               size_i     access size code                                |
// |               unsigned_i zero-extend loads when 1                        |
// |               wdata_i    right-aligned store data                        |
// |               ldata_o    extended load result                            |
// |               sdata_o    store data placed on lanes                      |
// |               smask_o    byte-lane write enables                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ldata_o,
    output logic [31:0] sdata_o,
    output logic [3:0]  smask_o
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_byte = rword_i[{offset_i, 3'b000} +: 8];
    assign load_half = rword_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        ldata_o = '0;
        sdata_o = '0;
        smask_o = '0;
        case (size_i)
            SIZE_BYTE: begin
                ldata_o = {{24{~unsigned_i & load_byte[7]}}, load_byte};
                // Replicating onto every lane lets the mask alone pick the target byte.
                sdata_o = {4{wdata_i[7:0]}};
                smask_o = 4'b0001 << offset_i;
            end
            SIZE_HALF: begin
                ldata_o = {{16{~unsigned_i & load_half[15]}}, load_half};
                sdata_o = {2{wdata_i[15:0]}};
                smask_o = offset_i[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                ldata_o = rword_i;
                sdata_o = wdata_i;
                smask_o = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_mem_responder                                         |
// | Description : Responder for the memory-stage data bus. Accepts one       |
// |               load/store at a time, waits LATENCY cycles, commits the    |
// |               access at the edge entering RESP and pulses resp_valid.    |
// | Ports       : clk, reset (synchronous, active-high)                      |
// |               bus  data_mem_responder_if.slave                           |
// | Parameters  : DEPTH_WORDS (power of two), LATENCY (0..15), BASE_ADDR     |
// | Config      : DATA_MEM_MISALIGN_TRAP_EN - misaligned half/word accesses  |
// |               return an error instead of being silently aligned down.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);

    localparam int              IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    logic             write_q, uns_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lane_q, size_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_error_q, rsp_error_d;

    // ---------------- request decode ----------------
    logic [29:0]      word_off;
    logic             req_err;
    logic [1:0]       req_lane;

    assign word_off = bus.req_addr[31:2] - BASE_ADDR[31:2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic req_misal;
    assign req_misal = ((bus.req_size == SIZE_HALF) && bus.req_addr[0]) ||
                       ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
    assign req_err = (bus.req_size == SIZE_RSVD) || (bus.req_addr < BASE_ADDR) ||
                     ({2'b00, word_off} >= 32'(DEPTH_WORDS)) || req_misal;
`else
    assign req_err = (bus.req_size == SIZE_RSVD) || (bus.req_addr < BASE_ADDR) ||
                     ({2'b00, word_off} >= 32'(DEPTH_WORDS));
`endif

    // Low address bits that a half/word access cannot use are dropped here;
    // with trapping enabled those accesses are already flagged as errors.
    always_comb begin
        case (bus.req_size)
            SIZE_BYTE: req_lane = bus.req_addr[1:0];
            SIZE_HALF: req_lane = {bus.req_addr[1], 1'b0};
            default:   req_lane = 2'b00;
        endcase
    end

    // With LATENCY=0 the commit edge is the acceptance edge, so the live
    // request must be used directly instead of the latched copy.
    logic             cur_write, cur_uns, cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic [1:0]       cur_lane, cur_size;
    logic [31:0]      cur_wdata;
    logic             in_idle;

    assign in_idle   = (state_q == ST_IDLE);
    assign cur_write = in_idle ? bus.req_write          : write_q;
    assign cur_uns   = in_idle ? bus.req_unsigned       : uns_q;
    assign cur_err   = in_idle ? req_err                : err_q;
    assign cur_idx   = in_idle ? word_off[IDX_W-1:0]    : idx_q;
    assign cur_lane  = in_idle ? req_lane               : lane_q;
    assign cur_size  = in_idle ? bus.req_size           : size_q;
    assign cur_wdata = in_idle ? bus.req_wdata          : wdata_q;

    logic [31:0] ldata, sdata;
    logic [3:0]  smask;

    mem_lane_align u_lane (
        .rword_i    (mem_q[cur_idx]),
        .offset_i   (cur_lane),
        .size_i     (cur_size),
        .unsigned_i (cur_uns),
        .wdata_i    (cur_wdata),
        .ldata_o    (ldata),
        .sdata_o    (sdata),
        .smask_o    (smask)
    );

    // ---------------- FSM: next state ----------------
    logic accept, commit;

    assign accept = in_idle && bus.req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit      = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign rsp_error_d = cur_err;
    assign rsp_rdata_d = (cur_err || cur_write) ? 32'h0 : ldata;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_error_q <= rsp_error_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= bus.req_write;
            uns_q   <= bus.req_unsigned;
            err_q   <= req_err;
            idx_q   <= word_off[IDX_W-1:0];
            lane_q  <= req_lane;
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
        end
    end

    // Array is never cleared; a reset before the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && cur_write && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (smask[b]) mem_q[cur_idx][8*b +: 8] <= sdata[8*b +: 8];
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.busy       = (state_q == ST_WAIT) || (state_q == ST_RESP);
        bus.resp_valid = (state_q == ST_RESP);
        bus.resp_rdata = (state_q == ST_RESP) ? rsp_rdata_q : 32'h0;
        bus.resp_error = (state_q == ST_RESP) && rsp_error_q;
    end

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                      |
// | Description : Self-checking bench for data_mem_responder with a          |
// |               byte-array reference model of the memory.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (LAT),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory: 1024 bytes, little-endian, byte address = index.
    logic [7:0] mdl [0:1023];

    function automatic void model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [1:0] sz, input bit uns,
                                  output logic [31:0] rd, output bit er);
        int unsigned n;
        logic [31:0] a;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a  = addr;
        if (sz == 2'd3) er = 1'b1;
        if (addr >= 32'd1024) er = 1'b1;
        if ((addr % n) != 0) begin
`ifdef DATA_MEM_MISALIGN_TRAP_EN
            er = 1'b1;
`else
            a = addr - (addr % n);
`endif
        end
        if (er) return;
        if (wr) begin
            for (int i = 0; i < int'(n); i++) mdl[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(n); i++) v[8*i +: 8] = mdl[a + i];
            if (!uns && n < 4 && v[8*n-1]) begin
                for (int i = 8*int'(n); i < 32; i++) v[i] = 1'b1;
            end
            rd = v;
        end
    endfunction

    // Runs one access. Entered and left at #1 after a rising edge with the DUT idle.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input bit uns, input bit hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output bit tail_ok, output logic [31:0] exp_rd, output bit exp_er);
        model(wr, addr, wd, sz, uns, exp_rd, exp_er);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (bus.resp_valid === 1'b1) begin
                lat = j;
                rd  = bus.resp_rdata;
                er  = bus.resp_error;
                break;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        tail_ok = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1) && (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b required 1 0 0",
                     bus.req_ready, bus.resp_valid, bus.busy);
        end
        checks++;
        if (bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h error=%b required 0 0", bus.resp_rdata, bus.resp_error);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        txn(1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (lat != LAT + 1 || er !== 1'b0 || !tl) begin
            errors++;
            $display("FAIL sw_timing: lat=%0d err=%b tail=%0d required lat=%0d err=0 tail=1", lat, er, tl, LAT + 1);
        end
        txn(0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != LAT + 1) begin
            errors++;
            $display("FAIL lw_10: rdata=%h err=%b lat=%0d required deadbeef 0 %0d", rd, er, lat, LAT + 1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        txn(1, 32'h13, 32'h80, 2'd0, 0, 0, rd, er, lat, tl, xr, xe);
        txn(0, 32'h13, 32'h0, 2'd0, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_13: got %h required ffffff80", rd); end
        txn(0, 32'h13, 32'h0, 2'd0, 1, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_13: got %h required 00000080", rd); end
        txn(0, 32'h10, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h required 80adbeef", rd); end
    endtask

    task automatic test_half_lanes();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        txn(1, 32'h20, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        txn(1, 32'h22, 32'h8234, 2'd1, 0, 0, rd, er, lat, tl, xr, xe);
        txn(0, 32'h22, 32'h0, 2'd1, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'hFFFF8234) begin errors++; $display("FAIL lh_22: got %h required ffff8234", rd); end
        txn(0, 32'h22, 32'h0, 2'd1, 1, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h00008234) begin errors++; $display("FAIL lhu_22: got %h required 00008234", rd); end
        txn(0, 32'h20, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h82340000) begin errors++; $display("FAIL lw_after_sh: got %h required 82340000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        txn(1, 32'h0, 32'h12345678, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        txn(0, 32'h400, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || lat != LAT + 1) begin
            errors++;
            $display("FAIL lw_oob: err=%b rdata=%h lat=%0d required 1 0 %0d", er, rd, lat, LAT + 1);
        end
        txn(1, 32'h400, 32'hFFFFFFFF, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL sw_oob: err=%b required 1", er); end
        txn(0, 32'h0, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h12345678 || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_0_after_oob: got %h err=%b required 12345678 0", rd, er);
        end
        txn(0, 32'h0, 32'h0, 2'd3, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL size_rsvd: err=%b rdata=%h required 1 0", er, rd);
        end
        txn(1, 32'h3FF, 32'hA5, 2'd0, 0, 0, rd, er, lat, tl, xr, xe);
        txn(0, 32'h3FF, 32'h0, 2'd0, 1, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'hA5 || er !== 1'b0) begin
            errors++;
            $display("FAIL lbu_last_byte: got %h err=%b required 000000a5 0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        txn(0, 32'h11, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: err=%b rdata=%h required 1 0", er, rd);
        end
`else
        if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL lw_misaligned: err=%b rdata=%h required 0 80adbeef", er, rd);
        end
`endif
    endtask

    task automatic test_hold_valid();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        int pulses;
        txn(0, 32'h10, 32'h0, 2'd2, 0, 1, rd, er, lat, tl, xr, xe);
        checks++;
        if (lat != LAT + 1 || !tl) begin
            errors++;
            $display("FAIL hold_first: lat=%0d tail=%0d required %0d 1", lat, tl, LAT + 1);
        end
        pulses = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            if (bus.resp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL hold_second_accept: pulses=%0d required 0", pulses); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, xr; logic er; bit xe, tl; int lat;
        int pulses;
        txn(1, 32'h30, 32'h11, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        // Store accepted, then reset in the first WAIT cycle.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h30;
        bus.req_wdata = 32'h55; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: ready=%b busy=%b valid=%b required 1 0 0",
                     bus.req_ready, bus.busy, bus.resp_valid);
        end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        // Request presented together with reset must be dropped.
        bus.req_valid = 1'b1; bus.req_wdata = 32'h77;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_pulse: pulses=%0d required 0", pulses); end
        txn(0, 32'h30, 32'h0, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        checks++;
        if (rd !== 32'h11 || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write: got %h err=%b required 00000011 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, xr, addr; logic er; bit xe, tl; int lat;
        bit wr, uns; logic [1:0] sz; int r;
        for (int w = 0; w < 16; w++) begin
            txn(1, 32'(w * 4), $urandom, 2'd2, 0, 0, rd, er, lat, tl, xr, xe);
        end
        for (int n = 0; n < 80; n++) begin
            r   = int'($urandom_range(0, 9));
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = (r == 9) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 0)      addr = 32'h400 + $urandom_range(0, 255);
            else if (r == 1) addr = 32'hFFFF_FF00 | $urandom_range(0, 255);
            else             addr = $urandom_range(0, 63);
            txn(wr, addr, $urandom, sz, uns, 0, rd, er, lat, tl, xr, xe);
            checks++;
            if (rd !== xr || er !== xe || lat != LAT + 1 || !tl) begin
                errors++;
                $display("FAIL rand_%0d: wr=%0d addr=%h sz=%0d uns=%0d got rd=%h err=%b lat=%0d tail=%0d required rd=%h err=%0d lat=%0d tail=1",
                         n, wr, addr, sz, uns, rd, er, lat, tl, xr, xe, LAT + 1);
            end
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
        test_reset();
        test_word();
        test_byte_lanes();
        test_half_lanes();
        test_errors();
        test_misalign();
        test_hold_valid();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_responder
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU memory-stage data-access interface: accepts one load/store request at a time, models a configurable access latency, and returns one response pulse (the `mem_done` equivalent).
- Holds the data memory array internally.
- Handles RISC-V byte/half/word lanes, little-endian order, and sign/zero extension on loads.
- Replaces the single-cycle RAM behind the memory stage so that stage can be tested against real wait states.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two, ≥ 4).
- LATENCY, 2, wait cycles between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1 (lbu/lhu); ignored on stores.
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_error  output  1  qualified by resp_valid: access rejected.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset (synchronous, active-high, clock edge only): state goes to IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, busy=0. Array contents are not cleared.
- Handshake: a request is accepted when req_valid && req_ready at a rising edge. All request fields are latched at that edge. req_valid outside IDLE is ignored (no queueing).
- FSM IDLE→WAIT→RESP→IDLE:
  - With LATENCY=0, IDLE goes straight to RESP.
  - WAIT uses a 4-bit down-counter loaded with LATENCY-1 at acceptance. WAIT→RESP when the counter is 0.
  - RESP lasts exactly one cycle, then returns to IDLE.
- Timing: request accepted in cycle T ⇒ resp_valid high in cycle T+1+LATENCY. Next acceptance is possible in cycle T+2+LATENCY.
- Commit: store data is written, and load data is read, at the edge entering RESP. Both use the array contents from before that edge.
- Lanes, little-endian:
  - Byte uses addr[1:0]; half uses addr[1]; word uses all 4 lanes.
  - Stores merge only the selected lanes.
  - Loads sign-extend from bit 7 or 15 unless req_unsigned=1.
- Error conditions:
  - size=11;
  - addr < BASE_ADDR;
  - (addr-BASE_ADDR)>>2 ≥ DEPTH_WORDS;
  - misalignment (see Optional Feature).
  - On error: resp_error=1, resp_rdata=0, no array write. Latency is unchanged.
- Reset mid-operation (WAIT or RESP): the access is aborted. If reset arrives before the commit edge, no write occurs. No resp_valid is produced.
- Reset asserted in the same cycle as a request: the request is dropped.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, produces resp_error=1, no write, and resp_rdata=0.
- Undefined: the offending low address bits are forced to 0 (half→addr[1] kept, word→word aligned). The access completes normally with resp_error=0.

Decomposition:
- Package data_mem_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD;
  - FSM state enum ST_IDLE/ST_WAIT/ST_RESP;
  - LAT_W=4.
- Sub-module mem_lane_align (combinational):
  - Load path: word + offset + size + unsigned → extended data.
  - Store path: wdata + offset + size → shifted data and 4-bit byte mask.
  - Top-level block keeps the FSM, counter, array and error checks.

Test Plan:
- LATENCY=2: sw 0xDEADBEEF@0x10 accepted in cycle T → resp_valid only in T+3, error=0. Then lw 0x10 → rdata 0xDEADBEEF.
- After the above: sb 0x80@0x13 → lb 0x13 = 0xFFFFFF80, lbu 0x13 = 0x00000080, lw 0x10 = 0x80ADBEEF.
- sw 0@0x20, then sh 0x8234@0x22 → lh 0x22 = 0xFFFF8234, lhu 0x22 = 0x00008234, lw 0x20 = 0x82340000.
- DEPTH_WORDS=256: lw 0x400 → resp_error=1, rdata=0. sw 0xFFFFFFFF@0x400 followed by lw 0x0 returns the unchanged value. Holding req_valid high during busy produces no second acceptance.
- lw 0x11:
  - with DATA_MEM_MISALIGN_TRAP_EN → error=1, rdata=0;
  - without it → rdata equals lw 0x10, error=0.
- sw 0x55@0x30 (old value 0x11), reset pulsed in the first WAIT cycle → no resp_valid, req_ready=1 the cycle after reset. lw 0x30 → 0x11.
